// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding and the timeout-counter width.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      VALID,
      FAULT
   } state_e;

   localparam logic [31:0] PC_INCR = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts request cycles without an acknowledge.
// Expired flags the cycle that would make the count reach MAX_WAIT.
module fetch_wait_timer
   import fetch_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Clear,
   input  logic Enable,
   output logic Expired
);

   localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

   logic [WAIT_W-1:0] count_q;
   logic [WAIT_W-1:0] count_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_comb begin
      count_d = count_q;
      if (Clear) begin
         count_d = '0;
      end else if (Enable) begin
         count_d = count_q + 1'b1;
      end
   end

   assign Expired = Enable && (count_q == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues one imem request at a time,
// applies redirects, holds under stall and traps faults.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [31:0] ImemData,
   input  logic        RedirectValid,
   input  logic [31:0] RedirectTarget,
   input  logic        Stall,
   output logic        InstrValid,
   output logic [31:0] Instruction,
   output logic [31:0] InstrPC,
   output logic [31:0] PCPlus4,
   output logic        AlignFault,
   output logic        TimeoutFault
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        kill_q, kill_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] plus4_q, plus4_d;
   logic        valid_q, valid_d;
   logic        align_q, align_d;
   logic        tmo_q, tmo_d;

   logic in_req;
   logic wait_en;
   logic req_ack;
   logic expired;
   logic misaligned;

   assign in_req     = (state_q == REQ);
   assign wait_en    = in_req && !ImemAck;
   assign req_ack    = in_req && ImemAck;
   assign misaligned = RedirectValid && (RedirectTarget[1:0] != 2'b00);

   fetch_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .Clk     (Clk),
      .Reset   (Reset),
      .Clear   (req_ack),
      .Enable  (wait_en),
      .Expired (expired)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         pend_q  <= '0;
         kill_q  <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
         plus4_q <= '0;
         valid_q <= 1'b0;
         align_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         kill_q  <= kill_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         plus4_q <= plus4_d;
         valid_q <= valid_d;
         align_q <= align_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      kill_d  = kill_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      plus4_d = plus4_q;
      valid_d = valid_q;
      align_d = align_q;
      tmo_d   = tmo_q;
      if (state_q != FAULT && (expired || misaligned)) begin
         state_d = FAULT;
         valid_d = 1'b0;
         kill_d  = 1'b0;
         align_d = align_q | misaligned;
         tmo_d   = tmo_q | expired;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (RedirectValid) pc_d = RedirectTarget;
               state_d = REQ;
            end
            REQ: begin
               // Address is frozen mid-request, so a redirect is parked.
               if (ImemAck) begin
                  kill_d  = 1'b0;
                  state_d = IDLE;
                  if (RedirectValid) begin
                     pc_d = RedirectTarget;
                  end else if (kill_q) begin
                     pc_d = pend_q;
                  end else begin
                     instr_d = ImemData;
                     ipc_d   = pc_q;
                     plus4_d = pc_q + PC_INCR;
                     pc_d    = pc_q + PC_INCR;
                     valid_d = 1'b1;
                     state_d = VALID;
                  end
               end else if (RedirectValid) begin
                  pend_d = RedirectTarget;
                  kill_d = 1'b1;
               end
            end
            VALID: begin
               if (RedirectValid || !Stall) begin
                  valid_d = 1'b0;
                  state_d = REQ;
                  if (RedirectValid) pc_d = RedirectTarget;
               end
            end
            FAULT: ;
            default: ;
         endcase
      end
   end

   always_comb begin
      ImemReq      = in_req;
      ImemAddr     = pc_q;
      InstrValid   = valid_q;
      Instruction  = instr_q;
      InstrPC      = ipc_q;
      PCPlus4      = plus4_q;
      AlignFault   = align_q;
      TimeoutFault = tmo_q;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a
// behavioural fetch model; all outputs compared every cycle.
module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam int MAXW = 5;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck = 1'b0;
   logic [31:0] ImemData = '0;
   logic        RedirectValid = 1'b0;
   logic [31:0] RedirectTarget = '0;
   logic        Stall = 1'b0;
   logic        InstrValid;
   logic [31:0] Instruction;
   logic [31:0] InstrPC;
   logic [31:0] PCPlus4;
   logic        AlignFault;
   logic        TimeoutFault;

   int n_chk = 0;
   int n_fail = 0;

   // behavioural model state
   logic [31:0] m_pc, m_pend, m_ins, m_ipc, m_p4;
   bit m_busy, m_have, m_faulted, m_kill, m_af, m_tf;
   int m_wait;

   fetch_sequencer #(
      .RESET_VECTOR (RV),
      .MAX_WAIT     (MAXW)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .ImemReq        (ImemReq),
      .ImemAddr       (ImemAddr),
      .ImemAck        (ImemAck),
      .ImemData       (ImemData),
      .RedirectValid  (RedirectValid),
      .RedirectTarget (RedirectTarget),
      .Stall          (Stall),
      .InstrValid     (InstrValid),
      .Instruction    (Instruction),
      .InstrPC        (InstrPC),
      .PCPlus4        (PCPlus4),
      .AlignFault     (AlignFault),
      .TimeoutFault   (TimeoutFault)
   );

   always #5 Clk = ~Clk;

   task automatic model_reset();
      m_pc = RV; m_pend = '0; m_ins = '0; m_ipc = '0; m_p4 = '0;
      m_busy = 0; m_have = 0; m_faulted = 0; m_kill = 0;
      m_af = 0; m_tf = 0; m_wait = 0;
   endtask

   task automatic model_step();
      bit bad, tmo;
      if (Reset) begin
         model_reset();
         return;
      end
      if (m_faulted) return;
      bad = RedirectValid && (RedirectTarget % 4 != 0);
      tmo = m_busy && !ImemAck && (m_wait + 1 == MAXW);
      if (bad || tmo) begin
         m_af = m_af | bad;
         m_tf = m_tf | tmo;
         m_faulted = 1; m_busy = 0; m_have = 0; m_kill = 0;
      end else if (m_busy) begin
         if (ImemAck) begin
            m_wait = 0;
            m_busy = 0;
            if (RedirectValid) m_pc = RedirectTarget;
            else if (m_kill) m_pc = m_pend;
            else begin
               m_ins = ImemData; m_ipc = m_pc; m_p4 = m_pc + 4;
               m_pc = m_pc + 4; m_have = 1;
            end
            m_kill = 0;
         end else begin
            m_wait++;
            if (RedirectValid) begin
               m_pend = RedirectTarget; m_kill = 1;
            end
         end
      end else if (m_have) begin
         if (RedirectValid) begin
            m_have = 0; m_pc = RedirectTarget; m_busy = 1;
         end else if (!Stall) begin
            m_have = 0; m_busy = 1;
         end
      end else begin
         if (RedirectValid) m_pc = RedirectTarget;
         m_busy = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/req"}, 32'(ImemReq), 32'(m_busy));
      chk({tag, "/addr"}, ImemAddr, m_pc);
      chk({tag, "/valid"}, 32'(InstrValid), 32'(m_have));
      chk({tag, "/instr"}, Instruction, m_ins);
      chk({tag, "/ipc"}, InstrPC, m_ipc);
      chk({tag, "/plus4"}, PCPlus4, m_p4);
      chk({tag, "/afault"}, 32'(AlignFault), 32'(m_af));
      chk({tag, "/tfault"}, 32'(TimeoutFault), 32'(m_tf));
   endtask

   task automatic tick(input string tag, input bit ack, input bit rv,
                       input logic [31:0] rt, input bit stall);
      ImemAck = ack;
      ImemData = $urandom;
      RedirectValid = rv;
      RedirectTarget = rt;
      Stall = stall;
      @(posedge Clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      model_reset();
      #1;
      check_all("rst_async");
      @(posedge Clk);
      model_step();
      #1;
      Reset = 1'b0;
      check_all("rst_release");
   endtask

   initial begin
      model_reset();
      #2;
      check_all("reset");
      chk("reset_addr", ImemAddr, RV);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      for (int i = 0; i < 6; i++) tick("seq", 1, 0, 0, 0);
      chk("seq_ipc", InstrPC, 32'h8);
      chk("seq_plus4", PCPlus4, 32'hC);
      tick("seq", 1, 0, 0, 0);
      tick("seq", 1, 0, 0, 0);
      tick("seq", 1, 0, 0, 0);
      chk("at10_addr", ImemAddr, 32'h10);

      tick("wait1", 0, 0, 0, 0);
      tick("wait2", 0, 1, 32'h100, 0);
      chk("hold_addr", ImemAddr, 32'h10);
      tick("wait3", 0, 0, 0, 0);
      chk("hold_addr3", ImemAddr, 32'h10);
      tick("killack", 1, 0, 0, 0);
      chk("kill_novalid", 32'(InstrValid), 32'h0);
      tick("after_kill", 0, 0, 0, 0);
      chk("redir_addr", ImemAddr, 32'h100);

      tick("v100", 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) tick("stall", 0, 0, 0, 1);
      chk("stall_ipc", InstrPC, 32'h100);
      tick("stall_redir", 0, 1, 32'h200, 1);
      chk("stall_redir_addr", ImemAddr, 32'h200);
      chk("stall_redir_valid", 32'(InstrValid), 32'h0);

      tick("v200", 1, 0, 0, 0);
      tick("misalign", 0, 1, 32'h102, 0);
      chk("align_fault", 32'(AlignFault), 32'h1);
      for (int i = 0; i < 12; i++)
         tick("faulted", $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
      do_reset();
      chk("fault_cleared", 32'(AlignFault), 32'h0);

      tick("t_idle", 0, 0, 0, 0);
      for (int i = 0; i < MAXW - 1; i++) tick("t_wait", 0, 0, 0, 0);
      chk("no_timeout_yet", 32'(TimeoutFault), 32'h0);
      tick("t_last", 0, 0, 0, 0);
      chk("timeout", 32'(TimeoutFault), 32'h1);
      chk("timeout_noreq", 32'(ImemReq), 32'h0);
      do_reset();

      tick("wrap_redir", 0, 1, 32'hFFFF_FFFC, 0);
      tick("wrap_ack", 1, 0, 0, 0);
      chk("wrap_plus4", PCPlus4, 32'h0);
      tick("wrap_req", 0, 0, 0, 0);
      chk("wrap_addr", ImemAddr, 32'h0);
      #2;
      Reset = 1'b1;
      model_reset();
      #1;
      chk("midreq_reset", 32'(ImemReq), 32'h0);
      check_all("midreq");
      @(posedge Clk);
      model_step();
      #1;
      Reset = 1'b0;

      for (int i = 0; i < 600; i++) begin
         logic [31:0] rt;
         rt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) rt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 49) == 0) do_reset();
         else tick("rand", $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) == 0, rt,
                   $urandom_range(0, 9) < 4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences every fetch.
- Issues one request at a time to instruction memory over a req/ack handshake.
- Applies branch/jump redirects, holds a fetched instruction under downstream stall, squashes in-flight fetches on redirect, and traps misaligned targets or a hung memory.
- Sits between the instruction memory and the decode stage; replaces the free-running PC register plus incrementer in the fetch unit.

Parameters:
RESET_VECTOR, 32'h00000000, PC value loaded on Reset.
MAX_WAIT, 255, ImemReq cycles without ImemAck before the timeout fault (1..255).

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high global reset.
ImemReq  output  1  fetch request; held until ImemAck.
ImemAddr  output  32  fetch address; equals internal PC; stable while ImemReq=1.
ImemAck  input  1  memory returns ImemData this cycle; ignored unless ImemReq=1.
ImemData  input  32  instruction word.
RedirectValid  input  1  branch/jump taken this cycle.
RedirectTarget  input  32  new PC when RedirectValid=1.
Stall  input  1  decode cannot accept; hold the current instruction.
InstrValid  output  1  Instruction/InstrPC/PCPlus4 are valid.
Instruction  output  32  registered fetched word.
InstrPC  output  32  address of Instruction.
PCPlus4  output  32  InstrPC+4, modulo 2^32.
AlignFault  output  1  sticky: misaligned redirect target.
TimeoutFault  output  1  sticky: MAX_WAIT expired.

Behaviour:
- Reset (asynchronous, immediate): PC=RESET_VECTOR, state=IDLE, kill=0, wait counter=0, all outputs 0 except ImemAddr=RESET_VECTOR.
- States: IDLE, REQ, VALID, FAULT. Each registered cycle honours exactly one event, in priority order: Reset > fault > redirect > ack > stall.
- IDLE: ImemReq=0, InstrValid=0. Next cycle goes to REQ. A redirect here loads PC<=RedirectTarget.
- REQ: ImemReq=1, ImemAddr=PC held stable. The wait counter increments each cycle without ImemAck.
  - Ack with kill=0 and no redirect: Instruction<=ImemData, InstrPC<=PC, PCPlus4<=PC+4, PC<=PC+4, InstrValid<=1, go to VALID.
  - Redirect without ack: the address cannot change mid-request, so pendingPC<=RedirectTarget and kill<=1; stay in REQ. A later redirect overwrites pendingPC (latest wins).
  - Ack with kill=1: discard ImemData, PC<=pendingPC, kill<=0, go to IDLE.
  - Ack in the same cycle as a redirect: discard ImemData, PC<=RedirectTarget, go to IDLE.
  - Counter reaching MAX_WAIT: TimeoutFault<=1, go to FAULT. The counter clears on every ack.
- VALID: InstrValid=1; outputs hold while Stall=1.
  - Stall=0: instruction consumed; InstrValid<=0, go to REQ. Throughput is 1 instruction per 2 cycles with zero-wait memory.
  - Redirect (wins over Stall): InstrValid<=0, PC<=RedirectTarget, go to REQ.
- Any redirect with RedirectTarget[1:0]!=0: AlignFault<=1, InstrValid<=0, go to FAULT. PC is not loaded.
- FAULT: ImemReq=0, InstrValid=0; all inputs ignored until Reset. Fault flags are sticky.
- PC arithmetic wraps: 32'hFFFFFFFC+4 = 32'h00000000, with no fault.
- Latency with ack in the same cycle as the request: Reset falls at edge 0; REQ in cycle 1; InstrValid=1 in cycle 2.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, REQ, VALID, FAULT);
  - PC_INCR=32'd4;
  - DEFAULT_RESET_VECTOR;
  - WAIT_W=8.
- One sub-module, fetch_wait_timer: an 8-bit counter with clear, enable and expired output. Clk/Reset style is identical to the parent.

Test Plan:
- Reset, ack asserted on every request, Stall=0: ImemAddr sequence 0x0,0x4,0x8; InstrValid pulses every 2nd cycle; PCPlus4 = InstrPC+4.
- Ack delayed 3 cycles at PC=0x10, with a redirect to 0x100 in the 2nd wait cycle: ImemAddr stays 0x10 until ack; data discarded (no InstrValid); next request is at 0x100.
- In VALID with Stall=1 for 4 cycles: outputs hold; with Stall=1 plus redirect to 0x200: InstrValid drops next cycle and the request goes to 0x200.
- Redirect to 0x102: AlignFault=1; ImemReq and InstrValid stay 0 for 10+ cycles; Reset clears the fault and the PC returns to RESET_VECTOR.
- MAX_WAIT=5 with ack never asserted: TimeoutFault rises after 5 REQ cycles and ImemReq drops.
- Redirect to 0xFFFFFFFC, then ack: PCPlus4=0x0 and the next ImemAddr=0x0; Reset asserted mid-REQ drops ImemReq before the next Clk edge.
